// File: rtl/rf_seq_pkg.sv
// Shared widths, opcodes, state encodings and control-word layout for rf_sequencer.
package rf_seq_pkg;

    localparam int unsigned IR_W  = 16;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned RA_W  = 4;
    localparam int unsigned DA_W  = 8;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned RFS_W = 2;
    localparam int unsigned ST_W  = 4;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_STORE = 4'b0001;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0011;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0100;
    localparam logic [OP_W-1:0] OP_HALT  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LOADC = 4'b0110;

    localparam logic [RFS_W-1:0] RF_S_ALU = 2'b00;
    localparam logic [RFS_W-1:0] RF_S_MEM = 2'b01;
    localparam logic [RFS_W-1:0] RF_S_IMM = 2'b10;

    localparam logic [ALU_W-1:0] ALU_ZERO = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;

    typedef enum logic [ST_W-1:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_LOADC  = 4'd10
    } state_e;

    // One cycle's worth of datapath control, registered as a unit.
    typedef struct packed {
        logic             pc_clr;
        logic             pc_up;
        logic             ir_ld;
        logic [DA_W-1:0]  d_addr;
        logic             d_wr;
        logic [RFS_W-1:0] rf_s;
        logic [RA_W-1:0]  rf_w_addr;
        logic             rf_w_en;
        logic [RA_W-1:0]  rf_ra_addr;
        logic             rf_ra_en;
        logic [RA_W-1:0]  rf_rb_addr;
        logic             rf_rb_en;
        logic [ALU_W-1:0] alu_s;
        logic             halted;
    } ctrl_t;

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c        = '0;
        c.pc_clr = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/rf_sequencer.sv
// Control FSM for the lab processor: fetch, decode and sequence RF / data RAM / ALU.
// Define RF_SEQ_LOADC_EN to enable the LOADC (load immediate) instruction on opcode 0110.
module rf_sequencer
    import rf_seq_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic [IR_W-1:0]  IR,
    output logic             PC_clr,
    output logic             PC_up,
    output logic             IR_ld,
    output logic [DA_W-1:0]  D_addr,
    output logic             D_wr,
    output logic [RFS_W-1:0] RF_s,
    output logic [RA_W-1:0]  RF_W_addr,
    output logic             RF_W_en,
    output logic [RA_W-1:0]  RF_Ra_addr,
    output logic             RF_Ra_en,
    output logic [RA_W-1:0]  RF_Rb_addr,
    output logic             RF_Rb_en,
    output logic [ALU_W-1:0] ALU_s0,
    output logic             Halted,
    output logic [ST_W-1:0]  OutState
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    logic [OP_W-1:0] op;
    logic [RA_W-1:0] ir_ra, ir_rb, ir_rc;
    logic [DA_W-1:0] ir_addr;

    assign op      = IR[15:12];
    assign ir_ra   = IR[11:8];
    assign ir_rb   = IR[7:4];
    assign ir_rc   = IR[3:0];
    assign ir_addr = IR[7:0];

    // Control word is decoded from the next state so outputs stay registered yet Moore-timed.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_INIT;
            ctrl_q  <= ctrl_reset();
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;

        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
`ifdef RF_SEQ_LOADC_EN
                    OP_LOADC: state_d = ST_LOADC;
`else
                    OP_LOADC: state_d = ST_NOOP;
`endif
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase

        // IR is stable from DECODE onward, so IR-derived fields are safe here.
        case (state_d)
            ST_INIT: ctrl_d.pc_clr = 1'b1;
            ST_FETCH: begin
                ctrl_d.ir_ld = 1'b1;
                ctrl_d.pc_up = 1'b1;
            end
            ST_STORE: begin
                ctrl_d.d_addr     = ir_addr;
                ctrl_d.d_wr       = 1'b1;
                ctrl_d.rf_ra_addr = ir_ra;
                ctrl_d.rf_ra_en   = 1'b1;
            end
            ST_LOAD_A: ctrl_d.d_addr = ir_addr;
            ST_LOAD_B: begin
                ctrl_d.d_addr    = ir_addr;
                ctrl_d.rf_s      = RF_S_MEM;
                ctrl_d.rf_w_addr = ir_ra;
                ctrl_d.rf_w_en   = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                ctrl_d.rf_ra_addr = ir_rb;
                ctrl_d.rf_ra_en   = 1'b1;
                ctrl_d.rf_rb_addr = ir_rc;
                ctrl_d.rf_rb_en   = 1'b1;
                ctrl_d.rf_s       = RF_S_ALU;
                ctrl_d.alu_s      = (state_d == ST_ADD) ? ALU_ADD : ALU_SUB;
                ctrl_d.rf_w_addr  = ir_ra;
                ctrl_d.rf_w_en    = 1'b1;
            end
`ifdef RF_SEQ_LOADC_EN
            ST_LOADC: begin
                ctrl_d.rf_s      = RF_S_IMM;
                ctrl_d.rf_w_addr = ir_ra;
                ctrl_d.rf_w_en   = 1'b1;
            end
`endif
            ST_HALT: ctrl_d.halted = 1'b1;
            default: ctrl_d.alu_s  = ALU_ZERO;
        endcase
    end

    assign PC_clr     = ctrl_q.pc_clr;
    assign PC_up      = ctrl_q.pc_up;
    assign IR_ld      = ctrl_q.ir_ld;
    assign D_addr     = ctrl_q.d_addr;
    assign D_wr       = ctrl_q.d_wr;
    assign RF_s       = ctrl_q.rf_s;
    assign RF_W_addr  = ctrl_q.rf_w_addr;
    assign RF_W_en    = ctrl_q.rf_w_en;
    assign RF_Ra_addr = ctrl_q.rf_ra_addr;
    assign RF_Ra_en   = ctrl_q.rf_ra_en;
    assign RF_Rb_addr = ctrl_q.rf_rb_addr;
    assign RF_Rb_en   = ctrl_q.rf_rb_en;
    assign ALU_s0     = ctrl_q.alu_s;
    assign Halted     = ctrl_q.halted;
    assign OutState   = ST_W'(state_q);

endmodule
